sensor_node_if: RTL and testbench

- Sensor-side endpoint of the shared serial bus.
- The bus arbiter polls sensors by sending a one-byte sensor number. This block receives the poll and checks it against its own address.
- When addressed, it answers with two bytes: the latest sensor reading, then its checksum byte.
- It contains its own 8N1 UART receiver and transmitter, plus the response control FSM.

---
 rtl/sensor_node_if.sv | 239 +++++++++++++++++++++++
 tb/tb_sensor_node_if.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_node_if.sv
// sensor_node_if
//   Sensor-side endpoint of the shared serial bus. The arbiter polls with a
//   one-byte sensor number. When the number matches ADDR this node replies
//   with the latest sensor reading followed by its one's-complement check
//   byte, after a short idle gap.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per UART bit (>= 4)
//   ADDR         : this node's sensor number (1..7, 0 is the collision code)
//   GAP_BITS     : idle bit-times between poll stop bit and response start bit (>= 1)
//
// Ports
//   clock        : system clock
//   resetn       : asynchronous reset, active-low
//   rx           : serial input, asynchronous, idles high
//   tx           : serial output, idles high
//   sensor_data  : sample from the local sensor
//   sensor_valid : one-cycle strobe, loads sensor_data into the holding register
//   busy         : high from poll acceptance until the check-byte stop bit ends
//   polled       : one-cycle pulse when a matching poll is accepted
//   frame_err    : one-cycle pulse when a received byte has a bad stop bit
module sensor_node_if #(
  parameter int         CLKS_PER_BIT = 5208,
  parameter logic [2:0] ADDR         = 3'd1,
  parameter int         GAP_BITS     = 2
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       rx,
  output logic       tx,
  input  logic [7:0] sensor_data,
  input  logic       sensor_valid,
  output logic       busy,
  output logic       polled,
  output logic       frame_err
);

  localparam int GAP_CYC = GAP_BITS * CLKS_PER_BIT;
  localparam int MAX_CYC = (GAP_CYC > CLKS_PER_BIT) ? GAP_CYC : CLKS_PER_BIT;
  localparam int CW      = $clog2(MAX_CYC) + 1;

  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
  localparam logic [7:0]    POLL_BYTE = {5'b00000, ADDR};

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;
  typedef enum logic [1:0] {C_IDLE, C_GAP, C_DATA, C_CRC} ctlState_t;

  logic          r_rxMeta;
  logic          r_rxSync;
  logic [7:0]    r_hold;

  rxState_t      r_rxState;
  logic [CW-1:0] r_rxCnt;
  logic [2:0]    r_rxBit;
  logic [7:0]    r_rxShift;
  logic          r_rxWaitHigh;
  logic          r_rxDone;
  logic          r_frameErr;

  ctlState_t     r_ctlState;
  logic [CW-1:0] r_txCnt;
  logic [3:0]    r_txBit;
  logic [7:0]    r_txShift;
  logic [7:0]    r_snap;
  logic          r_tx;
  logic          r_busy;
  logic          r_polled;

  logic          w_accept;

  // Two-flop synchroniser; resets to the idle-high line level so no false
  // start bit is seen when reset is released.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_rxMeta <= 1'b1;
      r_rxSync <= 1'b1;
    end else begin
      r_rxMeta <= rx;
      r_rxSync <= r_rxMeta;
    end
  end

  // Holding register follows the sensor at all times; the response works
  // from a separate snapshot so late updates never corrupt a byte in flight.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_hold <= 8'h00;
    end else if (sensor_valid) begin
      r_hold <= sensor_data;
    end
  end

  // UART receiver. The start bit is re-checked at its middle to reject
  // glitches, then every later sample lands one full bit period on, i.e.
  // mid-bit. After a bad stop bit the line is still low, so the receiver
  // holds in RX_STOP until it goes high to avoid reading a phantom start.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_rxState    <= RX_IDLE;
      r_rxCnt      <= '0;
      r_rxBit      <= 3'd0;
      r_rxShift    <= 8'h00;
      r_rxWaitHigh <= 1'b0;
      r_rxDone     <= 1'b0;
      r_frameErr   <= 1'b0;
    end else begin
      r_rxDone   <= 1'b0;
      r_frameErr <= 1'b0;
      case (r_rxState)
        RX_IDLE: begin
          r_rxCnt <= '0;
          if (!r_rxSync) begin
            r_rxState <= RX_START;
          end
        end
        RX_START: begin
          if (r_rxCnt == HALF_LAST) begin
            r_rxCnt   <= '0;
            r_rxBit   <= 3'd0;
            r_rxState <= r_rxSync ? RX_IDLE : RX_DATA;
          end else begin
            r_rxCnt <= r_rxCnt + ONE;
          end
        end
        RX_DATA: begin
          if (r_rxCnt == BIT_LAST) begin
            r_rxCnt   <= '0;
            r_rxShift <= {r_rxSync, r_rxShift[7:1]};
            r_rxBit   <= r_rxBit + 3'd1;
            if (r_rxBit == 3'd7) begin
              r_rxState <= RX_STOP;
            end
          end else begin
            r_rxCnt <= r_rxCnt + ONE;
          end
        end
        RX_STOP: begin
          if (r_rxWaitHigh) begin
            if (r_rxSync) begin
              r_rxWaitHigh <= 1'b0;
              r_rxState    <= RX_IDLE;
            end
          end else if (r_rxCnt == BIT_LAST) begin
            r_rxCnt <= '0;
            if (r_rxSync) begin
              r_rxDone  <= 1'b1;
              r_rxState <= RX_IDLE;
            end else begin
              r_frameErr   <= 1'b1;
              r_rxWaitHigh <= 1'b1;
            end
          end else begin
            r_rxCnt <= r_rxCnt + ONE;
          end
        end
        default: r_rxState <= RX_IDLE;
      endcase
    end
  end

  // A poll is only taken when the node is free; r_rxShift still holds the
  // completed byte during the r_rxDone cycle.
  assign w_accept = r_rxDone && (r_rxShift == POLL_BYTE) && !r_busy;

  // Response controller and serializer. r_txBit walks the frame: 0 is the
  // start bit, 1..8 data, 9 stop. The shift register back-fills with ones,
  // so after eight shifts its LSB supplies the stop bit for free. The check
  // byte is loaded on the last cycle of the data stop bit, which makes its
  // start bit follow with no idle gap.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_ctlState <= C_IDLE;
      r_txCnt    <= '0;
      r_txBit    <= 4'd0;
      r_txShift  <= 8'hFF;
      r_snap     <= 8'h00;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_polled   <= 1'b0;
    end else begin
      r_polled <= 1'b0;
      case (r_ctlState)
        C_IDLE: begin
          if (w_accept) begin
            r_ctlState <= C_GAP;
            r_busy     <= 1'b1;
            r_polled   <= 1'b1;
            r_snap     <= r_hold;
            r_txCnt    <= '0;
          end
        end
        C_GAP: begin
          if (r_txCnt == GAP_LAST) begin
            r_ctlState <= C_DATA;
            r_txCnt    <= '0;
            r_txBit    <= 4'd0;
            r_txShift  <= r_snap;
            r_tx       <= 1'b0;
          end else begin
            r_txCnt <= r_txCnt + ONE;
          end
        end
        C_DATA, C_CRC: begin
          if (r_txCnt == BIT_LAST) begin
            r_txCnt <= '0;
            if (r_txBit == 4'd9) begin
              if (r_ctlState == C_DATA) begin
                r_ctlState <= C_CRC;
                r_txBit    <= 4'd0;
                r_txShift  <= ~r_snap;
                r_tx       <= 1'b0;
              end else begin
                r_ctlState <= C_IDLE;
                r_busy     <= 1'b0;
                r_tx       <= 1'b1;
              end
            end else begin
              r_txBit   <= r_txBit + 4'd1;
              r_tx      <= r_txShift[0];
              r_txShift <= {1'b1, r_txShift[7:1]};
            end
          end else begin
            r_txCnt <= r_txCnt + ONE;
          end
        end
        default: r_ctlState <= C_IDLE;
      endcase
    end
  end

  assign tx        = r_tx;
  assign busy      = r_busy;
  assign polled    = r_polled;
  assign frame_err = r_frameErr;

endmodule

// File: tb/tb_sensor_node_if.sv
// tb_sensor_node_if
//   Drives polls into sensor_node_if over its rx line and decodes the tx line
//   back into bytes. Expected reply bytes come from a simple model of the
//   node: a matching, well-framed poll while idle yields {hold, ~hold}.
module tb_sensor_node_if;

  localparam int         CPB      = 8;
  localparam logic [2:0] ADDR     = 3'd3;
  localparam int         GAP      = 2;
  localparam int         RESP_CYC = GAP * CPB + 20 * CPB;

  logic       clock        = 1'b0;
  logic       resetn       = 1'b0;
  logic       rx           = 1'b1;
  logic [7:0] sensor_data  = 8'h00;
  logic       sensor_valid = 1'b0;
  logic       tx;
  logic       busy;
  logic       polled;
  logic       frame_err;

  sensor_node_if #(
    .CLKS_PER_BIT(CPB),
    .ADDR        (ADDR),
    .GAP_BITS    (GAP)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .rx          (rx),
    .tx          (tx),
    .sensor_data (sensor_data),
    .sensor_valid(sensor_valid),
    .busy        (busy),
    .polled      (polled),
    .frame_err   (frame_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int         nCompared    = 0;
  int         nMismatched  = 0;
  logic [7:0] expTx[$];
  int         polledExp    = 0;
  int         polledSeen   = 0;
  int         frameErrExp  = 0;
  int         frameErrSeen = 0;
  logic [7:0] modelHold    = 8'h00;
  bit         abortFlag    = 1'b0;
  bit         firstOfResp  = 1'b0;
  int         lastPolledCyc = 0;
  int         busyLen      = 0;
  bit         busyAborted  = 1'b0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    nCompared++;
    if (actual != expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               name, actual, actual, expected, expected);
    end
  endtask

  // Pulse counters for polled / frame_err.
  always @(negedge clock) begin
    if (resetn && polled) begin
      polledSeen++;
      lastPolledCyc = cyc;
      firstOfResp   = 1'b1;
    end
    if (resetn && frame_err) frameErrSeen++;
  end

  // busy must stay high for exactly gap + two frames, unless reset cut it short.
  always @(negedge clock) begin
    if (busy) begin
      busyLen++;
    end else if (busyLen != 0) begin
      if (!busyAborted) checkOutput("busy_duration", busyLen, RESP_CYC);
      busyLen     = 0;
      busyAborted = 1'b0;
    end
  end

  always @(negedge resetn) begin
    abortFlag = 1'b1;
    if (busyLen != 0) busyAborted = 1'b1;
  end

  // tx decoder: finds a start bit, samples mid-bit, pops the scoreboard.
  initial begin : txMon
    int         startCyc;
    logic [7:0] b;
    logic       startBit;
    logic       stopBit;
    forever begin
      @(negedge clock);
      if (resetn && tx == 1'b0) begin
        startCyc  = cyc;
        abortFlag = 1'b0;
        if (firstOfResp) begin
          checkOutput("gap_cycles", startCyc - lastPolledCyc, GAP * CPB);
          firstOfResp = 1'b0;
        end
        repeat (CPB / 2) @(negedge clock);
        startBit = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clock);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clock);
        stopBit = tx;
        if (!abortFlag) begin
          checkOutput("tx_start_bit", int'(startBit), 0);
          checkOutput("tx_stop_bit", int'(stopBit), 1);
          if (expTx.size() == 0) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL tx_unexpected_byte: got 0x%02h, expected no byte", b);
          end else begin
            checkOutput("tx_byte", int'(b), int'(expTx.pop_front()));
          end
        end
      end
    end
  end

  task automatic sendByte(input logic [7:0] b, input bit goodStop);
    logic [9:0] frame;
    frame = {goodStop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = frame[i];
      repeat (CPB) @(posedge clock);
      #1;
    end
    rx = 1'b1;
  endtask

  // Reference behaviour of one received byte, then send it on the wire.
  task automatic applyStimulus(input logic [7:0] b, input bit goodStop, input bit nodeBusy);
    if (!goodStop) begin
      frameErrExp++;
    end else if (b == {5'b00000, ADDR} && !nodeBusy) begin
      polledExp++;
      expTx.push_back(modelHold);
      expTx.push_back(~modelHold);
    end
    sendByte(b, goodStop);
  endtask

  task automatic sensorLoad(input logic [7:0] v);
    sensor_data  = v;
    sensor_valid = 1'b1;
    @(posedge clock);
    #1;
    sensor_valid = 1'b0;
    modelHold    = v;
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    repeat (4) @(posedge clock);
    while (busy && n < 400) begin
      @(posedge clock);
      n++;
    end
    if (busy) checkOutput({name, "_idle_timeout"}, int'(busy), 0);
    repeat (12) @(posedge clock);
    #1;
  endtask

  task automatic checkScenario(input string name);
    checkOutput({name, "_polled_count"}, polledSeen, polledExp);
    checkOutput({name, "_frame_err_count"}, frameErrSeen, frameErrExp);
    checkOutput({name, "_tx_pending"}, expTx.size(), 0);
    checkOutput({name, "_tx_idle"}, int'(tx), 1);
    checkOutput({name, "_busy_idle"}, int'(busy), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stim
    logic [7:0] v;
    logic [7:0] b;
    bit         good;

    // Reset state
    resetn = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_tx", int'(tx), 1);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_polled", int'(polled), 0);
    checkOutput("reset_frame_err", int'(frame_err), 0);
    resetn = 1'b1;
    repeat (5) @(posedge clock);
    #1;

    // Basic poll
    $display("[TB] basic poll");
    sensorLoad(8'hA5);
    applyStimulus(8'h03, 1'b1, 1'b0);
    waitIdle("basic");
    checkScenario("basic");

    // Wrong address and upper bits set
    $display("[TB] non-matching polls");
    applyStimulus(8'h05, 1'b1, 1'b0);
    applyStimulus(8'h83, 1'b1, 1'b0);
    waitIdle("nomatch");
    checkScenario("nomatch");

    // Bad stop bit, then a clean poll
    $display("[TB] framing error");
    applyStimulus(8'h03, 1'b0, 1'b0);
    repeat (20) @(posedge clock);
    #1;
    waitIdle("frame_err");
    applyStimulus(8'h03, 1'b1, 1'b0);
    waitIdle("after_frame_err");
    checkScenario("frame_err");

    // Short glitch on rx
    $display("[TB] rx glitch");
    rx = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    rx = 1'b1;
    repeat (20) @(posedge clock);
    #1;
    applyStimulus(8'h03, 1'b1, 1'b0);
    waitIdle("glitch");
    checkScenario("glitch");

    // Sensor update during a response
    $display("[TB] snapshot");
    sensorLoad(8'h11);
    applyStimulus(8'h03, 1'b1, 1'b0);
    repeat (30) @(posedge clock);
    #1;
    sensorLoad(8'h3C);
    waitIdle("snap1");
    applyStimulus(8'h03, 1'b1, 1'b0);
    waitIdle("snap2");
    checkScenario("snapshot");

    // Poll arriving while busy
    $display("[TB] overlapping poll");
    sensorLoad(8'($urandom));
    applyStimulus(8'h03, 1'b1, 1'b0);
    applyStimulus(8'h03, 1'b1, 1'b1);
    waitIdle("overlap");
    checkScenario("overlap");

    // Reset in the middle of the data byte
    $display("[TB] reset mid-response");
    sensorLoad(8'($urandom));
    applyStimulus(8'h03, 1'b1, 1'b0);
    repeat (GAP * CPB + 40) @(posedge clock);
    #3;
    resetn = 1'b0;
    #1;
    checkOutput("abort_tx_high", int'(tx), 1);
    checkOutput("abort_busy_low", int'(busy), 0);
    expTx.delete();
    modelHold = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    resetn = 1'b1;
    repeat (250) @(posedge clock);
    #1;
    checkScenario("abort_quiet");
    applyStimulus(8'h03, 1'b1, 1'b0);
    waitIdle("after_abort");
    checkScenario("after_abort");

    // Random traffic
    $display("[TB] random traffic");
    for (int k = 0; k < 12; k++) begin
      v = 8'($urandom);
      sensorLoad(v);
      if ($urandom_range(0, 9) < 4) b = 8'h03;
      else                          b = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 9) != 0);
      applyStimulus(b, good, 1'b0);
      waitIdle("random");
      repeat ($urandom_range(5, 30)) @(posedge clock);
      #1;
    end
    checkScenario("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
